alu4_arbiter: RTL and testbench
===============================

ALU4_ARBITER -- requirements
Module: alu4_arbiter

Interface
REQ-001 SHALL use a single clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester k has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester k operation accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  4  operands (two's complement).
REQ-007 req0_op / req1_op  input  3  ALU control code, 000..111, passed through unchanged.
REQ-008 alu_a, alu_b  output  4  operands driven to the shared ALU.
REQ-009 alu_ctrl  output  3  control code driven to the shared ALU.
REQ-010 alu_result  input  4  combinational result returned by the shared ALU.
REQ-011 alu_nzcv  input  4  ALU flags, bit order {N,Z,C,V}.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_id  output  1  index of the served requester.
REQ-015 rsp_result / rsp_nzcv  output  4 / 4  captured result and flags.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE, with one operation in flight at most.
REQ-018 IDLE: if neither valid is high, SHALL stay in IDLE.
REQ-019 IDLE: if exactly one valid is high, SHALL grant that requester.
REQ-020 IDLE: if both valids are high, SHALL grant req0 when prio=0 and req1 when prio=1.
REQ-021 reqk_ready SHALL be combinational, high only in IDLE for the granted k, and never high for both requesters.
REQ-022 On grant, SHALL latch reqk_a/b/op into alu_a/alu_b/alu_ctrl, latch k into rsp_id, and go to EXEC.
REQ-023 alu_a/alu_b/alu_ctrl SHALL otherwise hold their last value.
REQ-024 EXEC (one cycle): SHALL capture alu_result into rsp_result and alu_nzcv into rsp_nzcv, then go to RESP.
REQ-025 RESP: rsp_valid SHALL be high.
REQ-026 RESP: rsp_result/rsp_nzcv/rsp_id SHALL stay stable until rsp_valid && rsp_ready.
REQ-027 On the response handshake, SHALL return to IDLE and set prio to the complement of rsp_id.
REQ-028 Latency: grant at edge T, rsp_valid high in the cycle after edge T+1.
REQ-029 Maximum throughput SHALL be one operation per 3 cycles, with no grant in the handshake cycle.
REQ-030 A requester's valid dropping while in EXEC/RESP SHALL have no effect; its inputs are sampled only at grant.
REQ-031 Flags SHALL pass through unmodified for all ops, including stale C/V on logic ops.
REQ-032 Unknown FSM encodings SHALL recover to IDLE on the next edge.

Reset
REQ-033 While rst_n=0, SHALL force state=IDLE and prio=0.
REQ-034 While rst_n=0, alu_a/alu_b/alu_ctrl, rsp_result, rsp_nzcv and rsp_id SHALL be 0.
REQ-035 While rst_n=0, rsp_valid, busy and both readys SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL discard the in-flight operation with no response.
REQ-037 The first grant after reset release SHALL follow REQ-018..020 with prio=0.

Verification
REQ-038 req0 add 0011+0100, op 000, rsp_ready=1 -> req0_ready 1 cycle; rsp_result=0111, rsp_nzcv=0000, rsp_id=0 two cycles after grant.
REQ-039 req1 add 0111+0001 -> rsp_result=1000, rsp_nzcv=1001, rsp_id=1.
REQ-040 Both valid from reset, req0 sub 0101-0101 (op 001), req1 eq 0010,0010 (op 111) -> req0 served first with rsp_result=0000 and Z=1; then req1 with rsp_result=0001; then prio=0.
REQ-041 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid stays high, outputs stable, no readys; handshake on cycle 6 returns to IDLE.
REQ-042 rst_n pulled low during EXEC -> all outputs 0 immediately; no response after release; a fresh req1 is granted normally.
REQ-043 Continuous valid on both requesters for 12 cycles -> grants alternate 0,1,0,1; one response every 3 cycles.

Source files
------------

// File: rtl/alu4_arbiter.sv
// rtl/alu4_arbiter.sv - two-requester arbiter in front of a shared 4-bit ALU
// One operation in flight; round-robin tie-break flips to the other requester after each response.
module alu4_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic       req1_valid,
   output logic       req0_ready,
   output logic       req1_ready,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   input  logic [2:0] req0_op,
   input  logic [2:0] req1_op,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_ctrl,
   input  logic [3:0] alu_result,
   input  logic [3:0] alu_nzcv,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [3:0] rsp_result,
   output logic [3:0] rsp_nzcv,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   prio;
   logic   gnt_any;
   logic   gnt_id;
   logic   grant;
   logic   handshake;

   // prio only breaks ties; a lone requester is always taken
   assign gnt_any   = req0_valid | req1_valid;
   assign gnt_id    = (req0_valid & req1_valid) ? prio : req1_valid;
   assign grant     = (state == IDLE) & gnt_any;
   assign handshake = (state == RESP) & rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = gnt_any ? EXEC : IDLE;
         EXEC:    state_nxt = RESP;
         RESP:    state_nxt = rsp_ready ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end

   // readys are gated by rst_n because reset forces IDLE, where a grant would otherwise show
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      busy       = 1'b0;
      rsp_valid  = 1'b0;
      if (rst_n) begin
         req0_ready = grant & ~gnt_id;
         req1_ready = grant & gnt_id;
      end
      busy      = (state != IDLE);
      rsp_valid = (state == RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio       <= 1'b0;
         alu_a      <= 4'd0;
         alu_b      <= 4'd0;
         alu_ctrl   <= 3'd0;
         rsp_id     <= 1'b0;
         rsp_result <= 4'd0;
         rsp_nzcv   <= 4'd0;
      end else begin
         if (grant) begin
            alu_a    <= gnt_id ? req1_a  : req0_a;
            alu_b    <= gnt_id ? req1_b  : req0_b;
            alu_ctrl <= gnt_id ? req1_op : req0_op;
            rsp_id   <= gnt_id;
         end
         if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_nzcv   <= alu_nzcv;
         end
         if (handshake) begin
            prio <= ~rsp_id;
         end
      end
   end

endmodule

// File: tb/tb_alu4_arbiter.sv
// tb/tb_alu4_arbiter.sv - randomized and directed bench for alu4_arbiter
// A transaction-level model tracks grants, the pending operation and the tie-break owner.
module tb_alu4_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic       req0_ready, req1_ready;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0] req0_op, req1_op;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_ctrl;
   logic [3:0] alu_result, alu_nzcv;
   logic       rsp_valid, rsp_ready, rsp_id;
   logic [3:0] rsp_result, rsp_nzcv;
   logic       busy;

   int errors = 0;
   int checks = 0;

   // model of one operation in flight: 0 = idle, 1 = executing, 2 = response pending
   int         phase = 0;
   logic       mprio = 1'b0;
   logic [3:0] ma = 4'd0, mb = 4'd0;
   logic [2:0] mop = 3'd0;
   logic       mid = 1'b0;
   logic [3:0] mres = 4'd0, mnzcv = 4'd0;
   int         grants_q[$];
   int         nrsp = 0;

   alu4_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_op(req0_op), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_nzcv(alu_nzcv),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_nzcv(rsp_nzcv), .busy(busy)
   );

   // shared ALU: logic ops report arbitrary C/V so pass-through of stale flags is exercised
   function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      logic [4:0] s;
      logic [3:0] r;
      logic       c, v;
      s = 5'd0;
      c = a[0] ^ b[1];
      v = a[1];
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b};        r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
         3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ~a;
         3'd6: r = ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
         default: r = (a == b) ? 4'd1 : 4'd0;
      endcase
      return {r[3], (r == 4'd0), c, v, r};
   endfunction

   assign {alu_nzcv, alu_result} = alu_fn(alu_a, alu_b, alu_ctrl);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int k, input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      if (k == 0) begin
         req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
      end
   endtask

   // called at a falling edge with inputs set; checks, crosses one rising edge, returns at the next falling edge
   task automatic tick();
      logic g_any, g_id, hs;
      #1;
      g_any = 1'b0;
      g_id  = 1'b0;
      hs    = 1'b0;
      if (phase == 0) begin
         g_any = req0_valid | req1_valid;
         g_id  = (req0_valid && req1_valid) ? mprio : req1_valid;
      end
      check("busy", 8'(busy), 8'(phase != 0));
      check("rsp_valid", 8'(rsp_valid), 8'(phase == 2));
      check("req0_ready", 8'(req0_ready), 8'(g_any && !g_id));
      check("req1_ready", 8'(req1_ready), 8'(g_any && g_id));
      check("alu_a", 8'(alu_a), 8'(ma));
      check("alu_b", 8'(alu_b), 8'(mb));
      check("alu_ctrl", 8'(alu_ctrl), 8'(mop));
      if (phase == 2) begin
         check("rsp_id", 8'(rsp_id), 8'(mid));
         check("rsp_result", 8'(rsp_result), 8'(mres));
         check("rsp_nzcv", 8'(rsp_nzcv), 8'(mnzcv));
         hs = rsp_ready;
      end
      if (g_any) begin
         ma  = g_id ? req1_a  : req0_a;
         mb  = g_id ? req1_b  : req0_b;
         mop = g_id ? req1_op : req0_op;
         mid = g_id;
         {mnzcv, mres} = alu_fn(ma, mb, mop);
         grants_q.push_back(int'(g_id));
      end
      @(posedge clk);
      if (g_any) phase = 1;
      else if (phase == 1) phase = 2;
      else if (phase == 2 && hs) begin
         phase = 0;
         mprio = ~mid;
         nrsp++;
      end
      @(negedge clk);
   endtask

   task automatic model_reset();
      phase = 0; mprio = 1'b0; ma = 4'd0; mb = 4'd0; mop = 3'd0;
      mid = 1'b0; mres = 4'd0; mnzcv = 4'd0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outs"}, {req0_ready, req1_ready, rsp_valid, busy, rsp_id, alu_ctrl}, 8'd0);
      check({tag, "_alu"}, {alu_a, alu_b}, 8'd0);
      check({tag, "_rsp"}, {rsp_result, rsp_nzcv}, 8'd0);
   endtask

   initial begin
      int base, r0;
      rst_n = 1'b0;
      rsp_ready = 1'b1;
      set_req(0, 1'b1, 4'd9, 4'd3, 3'd2);
      set_req(1, 1'b1, 4'd5, 4'd6, 3'd4);
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      set_req(0, 1'b0, 4'd0, 4'd0, 3'd0);
      set_req(1, 1'b0, 4'd0, 4'd0, 3'd0);
      @(negedge clk);
      tick();

      // req0 add 3+4
      set_req(0, 1'b1, 4'b0011, 4'b0100, 3'd0);
      tick();
      req0_valid = 1'b0;
      tick();
      check("add0_result", 8'(rsp_result), 8'b0111);
      check("add0_nzcv", 8'(rsp_nzcv), 8'b0000);
      check("add0_id", 8'(rsp_id), 8'd0);
      tick();

      // req1 add 7+1 overflows
      set_req(1, 1'b1, 4'b0111, 4'b0001, 3'd0);
      tick();
      req1_valid = 1'b0;
      tick();
      check("add1_result", 8'(rsp_result), 8'b1000);
      check("add1_nzcv", 8'(rsp_nzcv), 8'b1001);
      check("add1_id", 8'(rsp_id), 8'd1);
      tick();

      // tie from reset: req0 first, then req1, tie-break back to req0
      rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      set_req(0, 1'b1, 4'b0101, 4'b0101, 3'd1);
      set_req(1, 1'b1, 4'b0010, 4'b0010, 3'd7);
      tick();
      tick();
      check("tie_first_id", 8'(rsp_id), 8'd0);
      check("tie_sub_result", 8'(rsp_result), 8'd0);
      check("tie_sub_z", 8'(rsp_nzcv[2]), 8'd1);
      tick();
      tick();
      tick();
      check("tie_second_id", 8'(rsp_id), 8'd1);
      check("tie_eq_result", 8'(rsp_result), 8'b0001);
      tick();
      #1;
      check("tie_prio_back", 8'({req0_ready, req1_ready}), 8'b10);

      // both requesters continuously valid for 12 cycles
      base = grants_q.size();
      r0 = nrsp;
      for (int i = 0; i < 12; i++) begin
         set_req(0, 1'b1, 4'($urandom), 4'($urandom), 3'($urandom));
         set_req(1, 1'b1, 4'($urandom), 4'($urandom), 3'($urandom));
         tick();
      end
      check("stream_grants", 8'(grants_q.size() - base), 8'd4);
      check("stream_rsps", 8'(nrsp - r0), 8'd4);
      for (int i = 0; i < 4 && base + i < grants_q.size(); i++)
         check("stream_alt", 8'(grants_q[base + i]), 8'(i % 2));

      // consumer stalls five cycles in RESP while req1 waits
      set_req(1, 1'b0, 4'd0, 4'd0, 3'd0);
      set_req(0, 1'b1, 4'd6, 4'd2, 3'd3);
      rsp_ready = 1'b0;
      tick();
      req0_valid = 1'b0;
      tick();
      set_req(1, 1'b1, 4'd1, 4'd1, 3'd0);
      repeat (5) tick();
      rsp_ready = 1'b1;
      tick();
      check("stall_idle", 8'(busy), 8'd0);
      req1_valid = 1'b0;
      tick();

      // reset during EXEC discards the operation
      set_req(0, 1'b1, 4'd4, 4'd4, 3'd0);
      tick();
      req1_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      set_req(0, 1'b0, 4'd0, 4'd0, 3'd0);
      set_req(1, 1'b0, 4'd0, 4'd0, 3'd0);
      r0 = nrsp;
      repeat (3) tick();
      check("midrst_no_rsp", 8'(nrsp - r0), 8'd0);
      set_req(1, 1'b1, 4'd2, 4'd5, 3'd1);
      tick();
      req1_valid = 1'b0;
      tick();
      tick();
      check("midrst_fresh", 8'(nrsp - r0), 8'd1);

      // random traffic, including valids dropping mid-operation
      for (int i = 0; i < 400; i++) begin
         set_req(0, ($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom), 3'($urandom));
         set_req(1, ($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom), 3'($urandom));
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
